data_mem_responder: RTL and testbench

//  Memory-side responder for the datapath's data-memory request interface
//  (mem_addr/mem_wdata/mem_read/mem_write -> mem_rdata).

---
 rtl/data_mem_responder.sv | 119 +++++++++++
 tb/tb_data_mem_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM that takes a fixed number of BUSY cycles
// per access and stalls the pipeline's MEM stage until DONE. Illegal requests pulse mem_err.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          ACCESS_LAT  = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [CW-1:0] CNT_INIT = CW'(ACCESS_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [AW-1:0]   idx_reg;
  logic [31:0]     wdata_reg;
  logic            wr_reg;
  logic            err_reg;
  logic [31:0]     rdata_reg;

  logic [31:0]     ram [DEPTH_WORDS];

  logic            req;
  logic            illegal;
  logic [32:0]     offset;
  logic [AW-1:0]   idx;
  logic            commit;
  logic            commit_wr;

  // 33-bit offset so that addresses below BASE_ADDR cannot wrap into range
  assign offset  = {1'b0, mem_addr} - {1'b0, BASE_ADDR};
  assign idx     = offset[AW+1:2];
  assign req     = mem_read | mem_write;
  assign illegal = (mem_read & mem_write)
                 | (mem_addr[1:0] != 2'b00)
                 | (mem_addr < BASE_ADDR)
                 | (offset >= SPAN_BYTES);

  assign commit    = (state_reg == BUSY) && (cnt_reg == '0);
  // Gated by rstn so a reset coinciding with the commit edge suppresses the write
  assign commit_wr = rstn & commit & wr_reg;

  always_ff @(posedge clk) begin
    if (commit_wr) begin
      ram[idx_reg] <= wdata_reg;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      wr_reg    <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            if (illegal) begin
              state_reg <= DONE;
              err_reg   <= 1'b1;
              if (mem_read) begin
                rdata_reg <= '0;
              end
            end else begin
              state_reg <= BUSY;
              err_reg   <= 1'b0;
              cnt_reg   <= CNT_INIT;
              idx_reg   <= idx;
              wdata_reg <= mem_wdata;
              wr_reg    <= mem_write;
            end
          end
        end
        BUSY: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            state_reg <= DONE;
            if (!wr_reg) begin
              rdata_reg <= ram[idx_reg];
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem_rdata = rdata_reg;
  assign mem_stall = rstn & (((state_reg == IDLE) & req) | (state_reg == BUSY));
  assign mem_err   = (state_reg == DONE) & err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: transaction table plus hand-written
// reset / mid-access corner sequences.
module tb_data_mem_responder;

  logic        clk;
  logic        rstn;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_err;

  int n_cmp;
  int n_bad;

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .ACCESS_LAT (2),
    .BASE_ADDR  (32'h0)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata),
    .mem_stall(mem_stall),
    .mem_err  (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_stall;
    logic        exp_err;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge with the FSM in IDLE; returns likewise.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output int stalls,
                            output logic err, output logic [31:0] rdata);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wdata;
    stalls    = 0;
    forever begin
      @(negedge clk);
      if (!mem_stall) break;
      stalls++;
      if (stalls > 20) break;
      @(posedge clk);
      #1;
    end
    err       = mem_err;
    rdata     = mem_rdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          stalls;
    logic        err;
    logic [31:0] rdata;

    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{1'b0, 1'b1, 32'h10,   32'hCAFEBABE, 3, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        3, 1'b0, 1'b1, 32'hCAFEBABE};
    vecs[2]  = '{1'b0, 1'b1, 32'h13,   32'h55555555, 1, 1'b1, 1'b1, 32'hCAFEBABE};
    vecs[3]  = '{1'b1, 1'b0, 32'h10,   32'h0,        3, 1'b0, 1'b1, 32'hCAFEBABE};
    vecs[4]  = '{1'b1, 1'b0, 32'h1000, 32'h0,        1, 1'b1, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'hFFC,  32'hA5A55A5A, 3, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'hFFC,  32'h0,        3, 1'b0, 1'b1, 32'hA5A55A5A};
    vecs[7]  = '{1'b0, 1'b1, 32'h20,   32'h11112222, 3, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 32'h20,   32'hDEADBEEF, 1, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h20,   32'h0,        3, 1'b0, 1'b1, 32'h11112222};
    vecs[10] = '{1'b0, 1'b1, 32'h1004, 32'h77777777, 1, 1'b1, 1'b1, 32'h11112222};

    // Reset with a read request held
    rstn      = 1'b0;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    mem_addr  = 32'h10;
    mem_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_stall", {31'b0, mem_stall}, 32'd0);
      check("reset_rdata", mem_rdata, 32'h0);
      check("reset_err",   {31'b0, mem_err}, 32'd0);
    end
    $display("reset held with mem_read=1: stall=%0b rdata=%h err=%0b", mem_stall, mem_rdata, mem_err);
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, stalls, err, rdata);
      check($sformatf("v%0d_stall", i), 32'(stalls), 32'(vecs[i].exp_stall));
      check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      if (vecs[i].chk_rdata) begin
        check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      end
      $display("txn %0d: rd=%0b wr=%0b addr=%h wdata=%h -> stall=%0d err=%0b rdata=%h",
               i, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, stalls, err, rdata);
    end

    // Write aborted by reset in its first BUSY cycle
    mem_write = 1'b1;
    mem_addr  = 32'h20;
    mem_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    rstn      = 1'b0;
    mem_write = 1'b0;
    #1;
    check("abort_stall", {31'b0, mem_stall}, 32'd0);
    check("abort_rdata", mem_rdata, 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    run_access(1'b1, 1'b0, 32'h20, 32'h0, stalls, err, rdata);
    check("abort_read_rdata", rdata, 32'h11112222);
    check("abort_read_stall", 32'(stalls), 32'd3);
    $display("aborted write @20 then read: stall=%0d err=%0b rdata=%h", stalls, err, rdata);

    // Request changed while BUSY: latched write still lands at 0x30
    mem_write = 1'b1;
    mem_addr  = 32'h30;
    mem_wdata = 32'h0BADF00D;
    @(posedge clk);
    #1;
    mem_addr  = 32'h34;
    mem_wdata = 32'hFFFFFFFF;
    stalls = 1;
    forever begin
      @(negedge clk);
      if (!mem_stall) break;
      stalls++;
      if (stalls > 20) break;
      @(posedge clk);
      #1;
    end
    check("chg_stall", 32'(stalls), 32'd3);
    mem_write = 1'b0;
    @(posedge clk);
    #1;
    run_access(1'b1, 1'b0, 32'h30, 32'h0, stalls, err, rdata);
    check("chg_read_rdata", rdata, 32'h0BADF00D);
    check("chg_read_err", {31'b0, err}, 32'd0);
    $display("write @30 changed mid-access then read @30: rdata=%h err=%0b", rdata, err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
